window_3x3_former: RTL and testbench

- Downstream of the line buffer stage in the preparation module.
- Takes the current pixel plus the two delayed rows produced by the line buffers and assembles a 3x3 neighbourhood window, one per accepted pixel.
- Tracks row and column position so that only fully-populated windows are flagged valid.
- Feeds the filter core (median/convolution) with a packed 72-bit window and a valid strobe.

---
 rtl/window_3x3_former_pkg.sv | 9 +
 rtl/window_row_shift.sv | 16 +
 rtl/window_3x3_former.sv | 73 +++++++
 tb/tb_window_3x3_former.sv | 104 ++++++++++
 4 files changed

// File: rtl/window_3x3_former_pkg.sv
// window_3x3_former_pkg: shared widths, FSM states and window offset helper
package window_3x3_former_pkg;
    localparam int PIX_W = 8;
    localparam int WIN_N = 9;
    typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;
    function automatic int win_off(input int w, input int r, input int c);
        return w * (3 * r + c);
    endfunction
endpackage

// File: rtl/window_row_shift.sv
// window_row_shift: 3-tap pixel shift register, oldest sample in the low tap
module window_row_shift
    import window_3x3_former_pkg::*;
#(
    parameter int DATA_W = PIX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_W-1:0]   din,
    output logic [3*DATA_W-1:0] taps
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) taps <= '0;
        else if (en) taps <= {din, taps[3*DATA_W-1:DATA_W]};
endmodule

// File: rtl/window_3x3_former.sv
// window_3x3_former: assembles 3x3 windows from three row streams, flags full windows
module window_3x3_former
    import window_3x3_former_pkg::*;
#(
    parameter int COLS   = 17,
    parameter int ROWS   = 17,
    parameter int DATA_W = PIX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done_i,
    input  logic [DATA_W-1:0]       row0_i,
    input  logic [DATA_W-1:0]       row1_i,
    input  logic [DATA_W-1:0]       row2_i,
    output logic [WIN_N*DATA_W-1:0] window_o,
    output logic                    done_o,
    output logic                    frame_done_o
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [CW-1:0]             col_cnt;
    logic [RW-1:0]             row_cnt;
    logic [DATA_W-1:0]         row_in [3];
    logic [3*DATA_W-1:0]       taps [3];
    logic [WIN_N*DATA_W-1:0]   win_nxt;
    logic                      col_wrap, last, qualify;
    state_t                    state, state_nxt;

    assign row_in = '{row0_i, row1_i, row2_i};

    // window_o is loaded with the post-shift taps so it lands one cycle after the pixel
    for (genvar r = 0; r < 3; r++) begin : g_row
        window_row_shift #(.DATA_W(DATA_W)) u_row (
            .clk  (clk),
            .rst  (rst),
            .en   (done_i),
            .din  (row_in[r]),
            .taps (taps[r])
        );
        assign win_nxt[win_off(DATA_W, r, 0) +: 3*DATA_W] = {row_in[r], taps[r][3*DATA_W-1:DATA_W]};
    end

    assign col_wrap = col_cnt == CW'(COLS - 1);
    assign last     = done_i && col_wrap && row_cnt == RW'(ROWS - 1);
    assign qualify  = done_i && row_cnt >= RW'(2) && col_cnt >= CW'(2);

    always_comb begin
        state_nxt = state;
        if (last) state_nxt = DONE;
        else if (done_i) state_nxt = (qualify && !col_wrap) ? ACTIVE : FILL;
        else if (state == DONE) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state        <= IDLE;
            col_cnt      <= '0;
            row_cnt      <= '0;
            window_o     <= '0;
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            done_o       <= qualify;
            frame_done_o <= last;
            if (qualify) window_o <= win_nxt;
            if (done_i) begin
                col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;
                if (col_wrap) row_cnt <= last ? '0 : row_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_window_3x3_former.sv
// tb_window_3x3_former: directed 4x4-frame checks of window assembly, gaps, frame end and reset
module tb_window_3x3_former;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done_i = 1'b0;
    logic [7:0]  row0_i = '0, row1_i = '0, row2_i = '0;
    logic [71:0] window_o;
    logic        done_o, frame_done_o;
    logic [71:0] exp_w = '0;
    int          checks = 0;
    int          errors = 0;

    window_3x3_former #(.COLS(4), .ROWS(4), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .done_i       (done_i),
        .row0_i       (row0_i),
        .row1_i       (row1_i),
        .row2_i       (row2_i),
        .window_o     (window_o),
        .done_o       (done_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    // pixel n of a 4-wide frame: element (r,c) is n - 4*(2-r) - (2-c)
    function automatic logic [71:0] exp_win(input int n);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = 8'(n - 4*(2-r) - (2-c));
        return w;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit v, input int n);
        done_i = v;
        row2_i = 8'(n);
        row1_i = n >= 4 ? 8'(n - 4) : 8'd0;
        row0_i = n >= 8 ? 8'(n - 8) : 8'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int n);
        bit q;
        step(1'b1, n);
        q = (n / 4 >= 2) && (n % 4 >= 2);
        if (q) exp_w = exp_win(n);
        check($sformatf("done_px%0d", n), {71'd0, done_o}, {71'd0, q});
        check($sformatf("win_px%0d", n), window_o, exp_w);
        check($sformatf("fdone_px%0d", n), {71'd0, frame_done_o}, {71'd0, n == 15});
    endtask

    task automatic gap(input int n);
        step(1'b0, n);
        check("done_gap", {71'd0, done_o}, 72'd0);
        check("win_gap", window_o, exp_w);
        check("fdone_gap", {71'd0, frame_done_o}, 72'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {71'd0, done_o}, 72'd0);
        check("rst_win", window_o, 72'd0);
        check("rst_fdone", {71'd0, frame_done_o}, 72'd0);
        rst = 1'b1;
        // frame 1: fill, line wrap, idle gap before pixel 14, frame end
        for (int n = 0; n < 14; n++) pix(n);
        for (int g = 0; g < 3; g++) gap(13);
        pix(14);
        pix(15);
        check("win_px10_literal", exp_win(10), 72'h0a_09_08_06_05_04_02_01_00);
        // next frame starts with no bubble: first pixel is (0,0)
        for (int n = 0; n < 11; n++) pix(n);
        // asynchronous mid-frame reset, away from the clock edge
        rst = 1'b0;
        #1;
        exp_w = '0;
        check("mid_rst_done", {71'd0, done_o}, 72'd0);
        check("mid_rst_win", window_o, 72'd0);
        check("mid_rst_fdone", {71'd0, frame_done_o}, 72'd0);
        done_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int n = 0; n < 16; n++) pix(n);
        step(1'b0, 0);
        check("idle_done", {71'd0, done_o}, 72'd0);
        check("idle_fdone", {71'd0, frame_done_o}, 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
